// File: rtl/udma_uart_rx_fifo.sv
// UART receive engine for the uDMA UART peripheral: 2-flop input synchroniser,
// mid-bit sampling FSM (5-8 data bits, optional parity, 1/2 stop bits),
// show-ahead RX FIFO and sticky parity/frame/overflow error flags.
module udma_uart_rx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          cfg_en_i,
    input  logic [DIV_W-1:0]              cfg_div_i,
    input  logic [1:0]                    cfg_bits_i,
    input  logic                          cfg_parity_en_i,
    input  logic                          cfg_parity_odd_i,
    input  logic                          cfg_stop2_i,
    input  logic                          cfg_clr_i,
    input  logic                          cfg_err_clr_i,
    input  logic                          uart_rx_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          rx_char_event_o,
    output logic                          err_parity_o,
    output logic                          err_frame_o,
    output logic                          err_overflow_o,
    output logic                          busy_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;

    logic             rx_meta_q, rxs_q, rxs_prev_q;
    state_e           state_q, state_d;
    logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             stop_idx_q, stop_idx_d;
    logic             bad_par_q, bad_par_d;
    logic             bad_frm_q, bad_frm_d;
    logic             done_q, done_d;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_par_q, err_par_d;
    logic             err_frm_q, err_frm_d;
    logic             err_ovf_q, err_ovf_d;

    logic             sample, full, pop, push_req, push;
    logic [2:0]       last_bit;

    assign sample   = (baud_cnt_q == '0);
    assign last_bit = {1'b0, cfg_bits_i} + 3'd4;

    // Two-flop synchroniser for the pad input plus one delayed copy for edge detection.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= uart_rx_i;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // Receive FSM next-state: baud counter samples at zero, bits assembled LSB-first.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        stop_idx_d = stop_idx_q;
        bad_par_d  = bad_par_q;
        bad_frm_d  = bad_frm_q;
        done_d     = 1'b0;
        if (!cfg_en_i) begin
            state_d = ST_IDLE;
        end else begin
            if (state_q != ST_IDLE) begin
                baud_cnt_d = sample ? cfg_div_i : baud_cnt_q - DIV_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (rxs_prev_q && !rxs_q) begin
                        state_d    = ST_START;
                        baud_cnt_d = cfg_div_i >> 1;
                    end
                end
                ST_START: begin
                    if (sample) begin
                        if (rxs_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d    = ST_DATA;
                            bit_idx_d  = '0;
                            shreg_d    = '0;
                            stop_idx_d = 1'b0;
                            bad_par_d  = 1'b0;
                            bad_frm_d  = 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (sample) begin
                        shreg_d[bit_idx_q] = rxs_q;
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == last_bit) begin
                            state_d = cfg_parity_en_i ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (sample) begin
                        bad_par_d = (rxs_q != ((^shreg_q) ^ cfg_parity_odd_i));
                        state_d   = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (sample) begin
                        bad_frm_d  = bad_frm_q | ~rxs_q;
                        stop_idx_d = 1'b1;
                        // Leave at mid-bit of the last stop so the next start edge is seen early.
                        if (stop_idx_q == cfg_stop2_i) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Receive FSM state registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            stop_idx_q <= 1'b0;
            bad_par_q  <= 1'b0;
            bad_frm_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            stop_idx_q <= stop_idx_d;
            bad_par_q  <= bad_par_d;
            bad_frm_q  <= bad_frm_d;
            done_q     <= done_d;
        end
    end

    // Character completion, FIFO bookkeeping and sticky errors (set wins over clear).
    always_comb begin
        full     = (count_q == FULL_CNT);
        pop      = (count_q != '0) && ready_i && !cfg_clr_i;
        push_req = done_q && !bad_frm_q && !bad_par_q && !cfg_clr_i;
        push     = push_req && (!full || pop);
        if (cfg_clr_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        end
        err_frm_d = (done_q && bad_frm_q) || (err_frm_q && !cfg_err_clr_i);
        err_par_d = (done_q && !bad_frm_q && bad_par_q) || (err_par_q && !cfg_err_clr_i);
        err_ovf_d = (push_req && full && !pop) || (err_ovf_q && !cfg_err_clr_i);
    end

    // FIFO control and error flag registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            err_par_q <= 1'b0;
            err_frm_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            err_par_q <= err_par_d;
            err_frm_q <= err_frm_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    // FIFO storage; the assembled character stays in shreg_q through the completion cycle.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shreg_q;
        end
    end

    assign valid_o         = (count_q != '0);
    assign data_o          = valid_o ? mem_q[rd_ptr_q] : 8'h00;
    assign count_o         = count_q;
    assign rx_char_event_o = push;
    assign err_parity_o    = err_par_q;
    assign err_frame_o     = err_frm_q;
    assign err_overflow_o  = err_ovf_q;
    assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: doc/udma_uart_rx_fifo.md
Name: udma_uart_rx_fifo

Overview:
Parametrised UART receive engine with an integrated show-ahead RX FIFO, for the next-generation uDMA UART peripheral.
- Supports 5-8 data bits, optional even/odd parity, 1 or 2 stop bits, and a runtime baud divider.
- Buffers received characters so the uDMA RX channel can stall without losing data.
- Reports per-character events and sticky parity, frame and overflow errors.
- Sits between the pad-side RX signal and the uDMA RX channel valid/ready interface.

Parameters:
FIFO_DEPTH, 8, RX FIFO entries; power of 2, >= 2
DIV_W, 16, width of baud divider

Ports:
clk_i  in  1  peripheral clock; single clock domain
rstn_i  in  1  reset; asynchronous, active-low
cfg_en_i  in  1  receiver enable
cfg_div_i  in  DIV_W  bit period = cfg_div_i+1 clk_i cycles; minimum value 3
cfg_bits_i  in  2  data bits = cfg_bits_i+5
cfg_parity_en_i  in  1  parity bit present
cfg_parity_odd_i  in  1  1 = odd parity, 0 = even parity
cfg_stop2_i  in  1  1 = two stop bits
cfg_clr_i  in  1  FIFO flush pulse
cfg_err_clr_i  in  1  clears sticky error flags
uart_rx_i  in  1  serial input from pad (asynchronous)
data_o  out  8  FIFO head, zero-extended
valid_o  out  1  FIFO not empty
ready_i  in  1  consumer accepts head
count_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
rx_char_event_o  out  1  one-cycle pulse per character pushed into the FIFO
err_parity_o  out  1  sticky flag
err_frame_o  out  1  sticky flag
err_overflow_o  out  1  sticky flag
busy_o  out  1  FSM not IDLE

Behaviour:
Reset values:
- All outputs 0, data_o = 0.
- Synchroniser flops reset to 1; FSM in IDLE; FIFO empty.

Input synchronisation:
- uart_rx_i passes through a 2-flop synchroniser.
- All FSM logic uses the synchronised value rxs.

Baud counter:
- Loaded on state entry, decrements to 0. A sample is taken at 0, then the counter reloads with cfg_div_i.

FSM states and transitions:
- IDLE: requires cfg_en_i = 1. On a 1->0 transition of rxs, go to START and load the counter with cfg_div_i>>1 (mid-bit).
- START: at sample, rxs = 0 -> DATA; rxs = 1 -> IDLE (glitch rejected, no error raised).
- DATA: shift rxs in LSB-first. After cfg_bits_i+5 samples -> PARITY if cfg_parity_en_i, else STOP.
- PARITY: expected parity = XOR(data bits) ^ cfg_parity_odd_i. Mismatch marks the character bad-parity. Then -> STOP.
- STOP: sample 1 (and sample 2 if cfg_stop2_i). Any stop sample = 0 marks the character bad-frame. After the last stop sample -> IDLE immediately, at mid-bit, so the next start edge can be detected early.

Character completion (cycle after the last stop sample):
- Bad-frame: set err_frame_o, discard the character.
- Else bad-parity: set err_parity_o, discard the character.
- Else push to the FIFO and pulse rx_char_event_o in the same cycle.
- Push with FIFO full and no same-cycle pop: drop the character, set err_overflow_o, no event pulse.
- Push with FIFO full and a same-cycle pop: both succeed; count unchanged.

FIFO:
- Show-ahead: data_o = head, valid_o = (count != 0).
- Pop when valid_o & ready_i.
- Read and write pointers wrap modulo FIFO_DEPTH.
- valid_o rises one cycle after the push cycle.

cfg_clr_i:
- Empties the FIFO; count_o = 0 next cycle.
- Any same-cycle push or pop is ignored. FSM is unaffected.

cfg_en_i = 0:
- FSM forced to IDLE; an in-progress character is discarded silently.
- FIFO contents are retained and remain poppable.

Configuration changes:
- cfg_div_i, cfg_bits_i, parity and stop settings are changed only while busy_o = 0. Mid-frame change gives undefined character data but no lockup.

Sticky errors:
- Cleared by cfg_err_clr_i.
- A set event in the same cycle as a clear wins (flag = 1).

Reset mid-frame: returns everything to reset values immediately (asynchronous).

Test Plan:
- 8N1, cfg_div_i = 15, send 0xA5 -> data_o = 0xA5, valid_o = 1, count_o = 1, one rx_char_event_o pulse, no errors.
- 7E2, send 0x35 with a wrong parity bit -> err_parity_o = 1, count_o stays 0, no event; cfg_err_clr_i -> flag = 0.
- FIFO_DEPTH = 8, ready_i = 0, send 9 chars 0x00..0x08 -> count_o = 8, err_overflow_o = 1; drain gives 0x00..0x07 in order.
- Low glitch of 4 cycles at cfg_div_i = 15 -> FSM returns to IDLE, no push, no error; stop bit driven 0 -> err_frame_o = 1, char dropped.
- 5N1, send 0x1F -> data_o = 0x1F (bits 7:5 zero); FIFO full with ready_i = 1 during push -> count_o stays 8, no overflow.
- Assert rstn_i = 0 mid-DATA -> busy_o = 0, valid_o = 0, count_o = 0 while in reset; next frame 0x3C received correctly.
